// File: rtl/dmac_nch_sequencer_if.sv
// Shared AHB master bus of the N-channel DMAC sequencer: address/data phase
// outputs from the sequencer, ready/response/read data back from the fabric.
interface dmac_nch_sequencer_if;
  logic [31:0] MAddress;
  logic [31:0] MWData;
  logic [1:0]  MTrans;
  logic [2:0]  MBurst_Size;
  logic        MWrite;
  logic [3:0]  MWStrb;
  logic        HReady;
  logic [1:0]  M_HResp;
  logic [31:0] MRData;

  modport master (
    output MAddress, MWData, MTrans, MBurst_Size, MWrite, MWStrb,
    input  HReady, M_HResp, MRData
  );

  modport slave (
    input  MAddress, MWData, MTrans, MBurst_Size, MWrite, MWStrb,
    output HReady, M_HResp, MRData
  );
endinterface

// File: rtl/dmac_nch_sequencer.sv
// N-channel DMAC sequencer: arbitrates requests, fetches a 4-word descriptor
// and hands the AHB master port to the granted channel engine.
// Optional build macro DMAC_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, lowest index wins).
//
// state  | meaning
// IDLE   | waiting for a pending request, arbitrating
// CFG_A  | descriptor word read, address phase
// CFG_D  | descriptor word read, data phase
// XFER   | channel engine owns the master port
// DONE   | completion pulse, release channel
// ERR    | bus error during fetch, abort
module dmac_nch_sequencer #(
  parameter int          NCH        = 4,
  parameter logic [31:0] CFG_BASE   = 32'h0000_0000,
  parameter logic [31:0] CFG_STRIDE = 32'h1000_0000,
  parameter logic [31:0] CFG_OFS    = 32'h0000_00A0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           DmacReq,
  dmac_nch_sequencer_if.master     ahb,
  input  logic [NCH*32-1:0]        ch_addr,
  input  logic [NCH*32-1:0]        ch_wdata,
  input  logic [NCH*2-1:0]         ch_trans,
  input  logic [NCH-1:0]           ch_write,
  input  logic [NCH*3-1:0]         ch_burst,
  input  logic [NCH*4-1:0]         ch_strb,
  input  logic [NCH-1:0]           ch_irq,
  output logic [NCH-1:0]           channel_en,
  output logic [31:0]              SAddr_Reg,
  output logic [31:0]              DAddr_Reg,
  output logic [31:0]              Size_Reg,
  output logic [31:0]              Ctrl_Reg,
  output logic [$clog2(NCH)-1:0]   active_ch,
  output logic                     busy,
  output logic                     irq,
  output logic                     err_irq
);
  localparam int CW = $clog2(NCH);
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_A, S_CFG_D, S_XFER, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      wcnt, wcnt_nx;
  logic [CW-1:0]   act_nx;
  logic [NCH-1:0]  pending, pend_clr, sel_mask;
  logic            rereq;
  logic            desc_ld, ctrl_clr;
  logic            grant_vld;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   scan_idx;

  assign sel_mask = NCH'(1) << active_ch;
  assign busy     = (state != S_IDLE);

`ifdef DMAC_ROUND_ROBIN_EN
  logic [CW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == S_DONE)
      rr_ptr <= CW'((int'(active_ch) + 1) % NCH);
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = CW'((int'(rr_ptr) + k) % NCH);
      if (!grant_vld && pending[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = CW'(k);
      if (!grant_vld && pending[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    wcnt_nx         = wcnt;
    act_nx          = active_ch;
    pend_clr        = '0;
    desc_ld         = 1'b0;
    ctrl_clr        = 1'b0;
    channel_en      = '0;
    irq             = 1'b0;
    err_irq         = 1'b0;
    ahb.MAddress    = '0;
    ahb.MWData      = '0;
    ahb.MTrans      = 2'b00;
    ahb.MBurst_Size = 3'b000;
    ahb.MWrite      = 1'b0;
    ahb.MWStrb      = 4'h0;
    case (state)
      S_IDLE: begin
        if (grant_vld) begin
          act_nx   = grant_idx;
          wcnt_nx  = 2'd0;
          state_nx = S_CFG_A;
        end
      end
      S_CFG_A: begin
        ahb.MTrans   = HTRANS_NONSEQ;
        ahb.MWStrb   = 4'hF;
        ahb.MAddress = CFG_BASE + (32'(active_ch) * CFG_STRIDE) + CFG_OFS
                       + {28'd0, wcnt, 2'b00};
        if (ahb.HReady)
          state_nx = S_CFG_D;
      end
      S_CFG_D: begin
        // An error response aborts immediately, even in its first (not-ready) cycle.
        if (ahb.M_HResp == HRESP_ERROR) begin
          state_nx = S_ERR;
        end else if (ahb.HReady && ahb.M_HResp == HRESP_OKAY) begin
          desc_ld = 1'b1;
          if (wcnt == 2'd3) begin
            state_nx = S_XFER;
          end else begin
            wcnt_nx  = wcnt + 2'd1;
            state_nx = S_CFG_A;
          end
        end
      end
      S_XFER: begin
        channel_en      = sel_mask;
        ahb.MAddress    = ch_addr[32*active_ch +: 32];
        ahb.MWData      = ch_wdata[32*active_ch +: 32];
        ahb.MTrans      = ch_trans[2*active_ch +: 2];
        ahb.MBurst_Size = ch_burst[3*active_ch +: 3];
        ahb.MWrite      = ch_write[active_ch];
        ahb.MWStrb      = ch_strb[4*active_ch +: 4];
        if (ch_irq[active_ch])
          state_nx = S_DONE;
      end
      S_DONE: begin
        irq      = 1'b1;
        ctrl_clr = 1'b1;
        pend_clr = rereq ? '0 : sel_mask;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        err_irq  = 1'b1;
        pend_clr = rereq ? '0 : sel_mask;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A request seen on the active channel after its grant survives the release.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      active_ch <= '0;
      pending   <= '0;
      rereq     <= 1'b0;
      SAddr_Reg <= '0;
      DAddr_Reg <= '0;
      Size_Reg  <= '0;
      Ctrl_Reg  <= '0;
    end else begin
      wcnt      <= wcnt_nx;
      active_ch <= act_nx;
      pending   <= (pending & ~pend_clr) | DmacReq;
      if (state == S_IDLE)
        rereq <= 1'b0;
      else if (|(DmacReq & sel_mask))
        rereq <= 1'b1;
      if (desc_ld) begin
        case (wcnt)
          2'd0:    SAddr_Reg <= ahb.MRData;
          2'd1:    DAddr_Reg <= ahb.MRData;
          2'd2:    Size_Reg  <= ahb.MRData;
          default: Ctrl_Reg  <= ahb.MRData;
        endcase
      end else if (ctrl_clr) begin
        Ctrl_Reg <= '0;
      end
    end
  end
endmodule
